// File: rtl/counter_sequencer.sv
// Command-driven sequencer for one up/down counter: LOAD / COUNT_UP / COUNT_DOWN
// over valid/ready, with wrap tracking, abort and a one-cycle done pulse.
module counter_sequencer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic              abort,
  output logic              cnt_enable,
  output logic              cnt_preload,
  output logic [WIDTH-1:0]  cnt_preload_data,
  output logic              cnt_mode,
  input  logic              cnt_detect,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              cmd_err,
  output logic [WCNT_W-1:0] wrap_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  logic [1:0]        state, state_nxt;
  logic [WIDTH-1:0]  steps, steps_nxt;
  logic [WIDTH-1:0]  pdata_nxt;
  logic              mode_nxt;
  logic              aborted_nxt, err_nxt;
  logic [WCNT_W-1:0] wrap_nxt;
  logic              enable_nxt, preload_nxt, busy_nxt, ready_nxt, done_nxt;
  logic              accept;

  assign accept = cmd_valid && cmd_ready;

  // Next-state, bookkeeping and next-output computation; outputs follow next state
  always_comb begin
    state_nxt = state;
    steps_nxt = steps;
    pdata_nxt = cnt_preload_data;
    mode_nxt  = cnt_mode;
    aborted_nxt = aborted;
    err_nxt   = cmd_err;
    wrap_nxt  = wrap_count;

    case (state)
      S_IDLE: begin
        if (accept) begin
          wrap_nxt    = '0;
          aborted_nxt = 1'b0;
          err_nxt     = 1'b0;
          case (cmd_op)
            OP_LOAD: begin
              state_nxt = S_LOAD;
              pdata_nxt = cmd_data;
            end
            OP_UP, OP_DOWN: begin
              if (cmd_data != '0) begin
                state_nxt = S_RUN;
                steps_nxt = cmd_data;
                mode_nxt  = cmd_op[1];
              end else begin
                state_nxt = S_DRAIN;
              end
            end
            default: begin
              state_nxt = S_DRAIN;
              err_nxt   = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: state_nxt = S_DRAIN;
      S_RUN: begin
        steps_nxt = steps - WIDTH'(1);
        if (abort) begin
          aborted_nxt = 1'b1;
          state_nxt   = S_DRAIN;
        end else if (steps == WIDTH'(1)) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if ((state == S_RUN || state == S_DRAIN) && cnt_detect && (wrap_count != '1))
      wrap_nxt = wrap_count + WCNT_W'(1);

    enable_nxt  = (state_nxt == S_LOAD) || (state_nxt == S_RUN);
    preload_nxt = (state_nxt == S_LOAD);
    busy_nxt    = (state_nxt != S_IDLE);
    ready_nxt   = (state_nxt == S_IDLE);
    done_nxt    = (state == S_DRAIN);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Registered outputs and step counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      steps            <= '0;
      cnt_enable       <= 1'b0;
      cnt_preload      <= 1'b0;
      cnt_preload_data <= '0;
      cnt_mode         <= 1'b0;
      busy             <= 1'b0;
      cmd_ready        <= 1'b1;
      done             <= 1'b0;
      aborted          <= 1'b0;
      cmd_err          <= 1'b0;
      wrap_count       <= '0;
    end else begin
      steps            <= steps_nxt;
      cnt_enable       <= enable_nxt;
      cnt_preload      <= preload_nxt;
      cnt_preload_data <= pdata_nxt;
      cnt_mode         <= mode_nxt;
      busy             <= busy_nxt;
      cmd_ready        <= ready_nxt;
      done             <= done_nxt;
      aborted          <= aborted_nxt;
      cmd_err          <= err_nxt;
      wrap_count       <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural up/down counter attached.
module tb_counter_sequencer;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned WCNT_W = 8;

  logic              clk;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [WIDTH-1:0]  cmd_data;
  logic              abort;
  logic              cnt_enable;
  logic              cnt_preload;
  logic [WIDTH-1:0]  cnt_preload_data;
  logic              cnt_mode;
  logic              cnt_detect;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              cmd_err;
  logic [WCNT_W-1:0] wrap_count;

  counter_sequencer #(.WIDTH(WIDTH), .WCNT_W(WCNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .abort(abort),
    .cnt_enable(cnt_enable), .cnt_preload(cnt_preload), .cnt_preload_data(cnt_preload_data),
    .cnt_mode(cnt_mode), .cnt_detect(cnt_detect),
    .busy(busy), .done(done), .aborted(aborted), .cmd_err(cmd_err), .wrap_count(wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: registered wrap detect; also tallies enables, preloads, run mode
  logic [WIDTH-1:0] cval;
  int               en_cnt, pl_cnt, done_cnt;
  logic             last_run_mode;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cval <= '0; cnt_detect <= 1'b0; en_cnt <= 0; pl_cnt <= 0; done_cnt <= 0;
      last_run_mode <= 1'b0;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (cnt_enable) begin
        en_cnt <= en_cnt + 1;
        if (cnt_preload) begin
          cval <= cnt_preload_data; cnt_detect <= 1'b0; pl_cnt <= pl_cnt + 1;
        end else if (!cnt_mode) begin
          cval <= cval + 4'd1; cnt_detect <= (cval == 4'hF); last_run_mode <= 1'b0;
        end else begin
          cval <= cval - 4'd1; cnt_detect <= (cval == 4'h0); last_run_mode <= 1'b1;
        end
      end else begin
        cnt_detect <= 1'b0;
      end
    end
  end

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command at the current (negedge) time; accepted at the next posedge
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Cycle index (1 = first cycle after accept) at which done is seen, bounded
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
    end while (!done && cyc < 40);
  endtask

  int cyc, en0, pl0, dn0;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_en",    32'(cnt_enable), 32'd0);
    check("rst_wrap",  32'(wrap_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset mid-RUN: COUNT_UP 10, reset in step 3
    issue(2'b01, 4'd10);
    repeat (3) @(negedge clk);
    check("midrun_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0; #1;
    check("midrst_en",    32'(cnt_enable), 32'd0);
    check("midrst_busy",  32'(busy), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_wrap",  32'(wrap_count), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt), 32'd0);

    // LOAD 0xA
    pl0 = pl_cnt; en0 = en_cnt;
    issue(2'b00, 4'hA);
    wait_done(cyc);
    check("load_done_cyc", 32'(cyc), 32'd3);
    check("load_preloads", 32'(pl_cnt - pl0), 32'd1);
    check("load_enables",  32'(en_cnt - en0), 32'd1);
    check("load_result",   32'(cval), 32'hA);
    check("load_wrap",     32'(wrap_count), 32'd0);
    @(negedge clk);
    check("load_done_pulse", 32'(done), 32'd0);

    // COUNT_UP 8 from 0xA wraps once
    en0 = en_cnt;
    issue(2'b01, 4'd8);
    @(negedge clk);
    check("up_ready_busy", 32'(cmd_ready), 32'd0);
    wait_done(cyc);
    check("up_done_cyc", 32'(cyc + 1), 32'd10);
    check("up_enables",  32'(en_cnt - en0), 32'd8);
    check("up_result",   32'(cval), 32'h2);
    check("up_wrap",     32'(wrap_count), 32'd1);
    check("up_aborted",  32'(aborted), 32'd0);
    check("up_mode",     32'(last_run_mode), 32'd0);

    // LOAD 0x3 then COUNT_DOWN 2
    issue(2'b00, 4'h3);
    wait_done(cyc);
    en0 = en_cnt;
    issue(2'b10, 4'd2);
    wait_done(cyc);
    check("down_done_cyc", 32'(cyc), 32'd4);
    check("down_enables",  32'(en_cnt - en0), 32'd2);
    check("down_mode",     32'(last_run_mode), 32'd1);
    check("down_result",   32'(cval), 32'h1);
    check("down_wrap",     32'(wrap_count), 32'd0);

    // Abort COUNT_UP 15 from 0 in the 4th RUN cycle
    issue(2'b00, 4'h0);
    wait_done(cyc);
    en0 = en_cnt;
    issue(2'b01, 4'd15);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk); cyc++;
    end
    check("abort_done_cyc", 32'(cyc), 32'd2);
    check("abort_enables",  32'(en_cnt - en0), 32'd4);
    check("abort_result",   32'(cval), 32'h4);
    check("abort_flag",     32'(aborted), 32'd1);
    @(negedge clk);
    check("abort_done_pulse", 32'(done), 32'd0);

    // COUNT_UP 0 then op 11 back-to-back
    en0 = en_cnt; dn0 = done_cnt;
    issue(2'b01, 4'd0);
    wait_done(cyc);
    check("n0_done_cyc", 32'(cyc), 32'd2);
    check("n0_err",      32'(cmd_err), 32'd0);
    check("n0_aborted",  32'(aborted), 32'd0);
    check("n0_ready",    32'(cmd_ready), 32'd1);
    issue(2'b11, 4'd5);
    wait_done(cyc);
    check("rsv_done_cyc", 32'(cyc), 32'd2);
    check("rsv_err",      32'(cmd_err), 32'd1);
    check("edge_enables", 32'(en_cnt - en0), 32'd0);
    check("edge_wrap",    32'(wrap_count), 32'd0);
    @(negedge clk);
    check("edge_done_count", 32'(done_cnt - dn0), 32'd2);
    check("rsv_err_held",    32'(cmd_err), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
